// File: rtl/simple_pkg.sv
// Shared definitions for the memory responder slice.
//   DEF_ADDR_W / DEF_DATA_W : default address and word widths
//   mem_state_t             : responder sequencing states
//   MEM_READ / MEM_WRITE    : encoding of the processor m_rw strobe
//   even_par()              : parity bit that makes {par, data} XOR to zero
package simple_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } mem_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic logic even_par(input logic [DEF_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with one write port and a registered,
// read-first output (a write returns the previous contents on q).
//   clock : write and read register clock
//   we    : write enable
//   addr  : shared read/write word address
//   wdata : write data
//   q     : registered read data (not reset; qualify downstream)
module sp_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/simple_mem_responder.sv
// Memory-side responder: owns the unified instruction/data RAM, zero-fills
// it after reset, accepts a host program load, then serves processor
// reads/writes with a fixed one-cycle read latency.
//   clock, reset                    : clock, synchronous active-high reset
//   m_addr, m_rw, m_data, m_q       : processor port (m_q registered)
//   load_valid/ready/addr/data/last : host program-load handshake
//   cpu_run                         : processor may execute
//   parity_err                      : sticky read parity error
// Optional build macro MEM_PARITY_EN adds a stored even-parity bit per word
// and checks it on every RUN read; without it parity_err is tied low.
//
// state | meaning
// ------+-----------------------------------------------
// CLEAR | zero-filling RAM, one word per cycle
// LOAD  | accepting host words until one marked last
// RUN   | processor owns the RAM; left only by reset
module simple_mem_responder
  import simple_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_rw,
  input  logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] m_q,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              cpu_run,
  output logic              parity_err
);

`ifdef MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_q;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = m_addr;
    wr_data   = m_data;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
        if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = LOAD;
      end
      LOAD: begin
        wr_addr = load_addr;
        wr_data = load_data;
        if (load_valid) begin
          wr_en = 1'b1;
          if (load_last) state_nxt = RUN;
        end
      end
      RUN: begin
        wr_en = (m_rw == MEM_WRITE);
      end
      default: state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;
    endcase
    // Reset aborts whatever transfer is in flight, including its write.
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;
      clr_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      rd_valid <= (state == RUN);
    end
  end

`ifdef MEM_PARITY_EN
  logic rd_chk;
  logic par_sticky;
  logic par_hit;

  assign ram_wdata = {^wr_data, wr_data};
  // A consistent word XORs to zero across data and stored parity.
  assign par_hit   = rd_chk & (^ram_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_chk     <= 1'b0;
      par_sticky <= 1'b0;
    end else begin
      rd_chk     <= (state == RUN) && (m_rw == MEM_READ);
      par_sticky <= par_sticky | par_hit;
    end
  end

  // par_hit is formed from registers only, so the error appears on the same
  // edge that presents the offending word on m_q.
  assign parity_err = par_sticky | par_hit;
`else
  assign ram_wdata  = wr_data;
  assign parity_err = 1'b0;
`endif

  sp_ram #(
    .WIDTH      (RAM_W),
    .DEPTH_LOG2 (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .addr  (wr_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // RAM output register is not reset; m_q reads as zero outside RUN.
  assign m_q        = rd_valid ? ram_q[DATA_W-1:0] : '0;
  assign load_ready = (state == LOAD);
  assign cpu_run    = (state == RUN);

endmodule

// File: tb/tb_simple_mem_responder.sv
module tb_simple_mem_responder;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 2**AW;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] m_addr;
  logic          m_rw;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_q;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          cpu_run;
  logic          parity_err;

  int tests  = 0;
  int errors = 0;

  always #5 clock = ~clock;

  simple_mem_responder #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data     (m_data),
    .m_q        (m_q),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .cpu_run    (cpu_run),
    .parity_err (parity_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m_addr = '0; m_rw = 1'b0; m_data = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
  endtask

  // Counts negedges until load_ready goes high (bounded).
  task automatic count_clear(output int n);
    n = 0;
    while (load_ready !== 1'b1 && n < 4 * DEPTH) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (load_ready !== 1'b0 || cpu_run !== 1'b0 || m_q !== '0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b run=%b m_q=%h perr=%b, want 0 0 0000 0",
               load_ready, cpu_run, m_q, parity_err);
    end
    reset = 1'b0;
    count_clear(n);
    tests++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_length: load_ready low for %0d cycles, want %0d", n, DEPTH);
    end
  endtask

  task automatic test_load();
    logic          v  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] a  [8] = '{6'h00, 6'h10, 6'h10, 6'h10, 6'h10, 6'h10, 6'h20, 6'h01};
    logic [DW-1:0] d  [8] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h1111, 16'hFFFF,
                              16'h2222, 16'h5A5A, 16'hABCD};
    logic          l  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      load_valid = v[i]; load_addr = a[i]; load_data = d[i]; load_last = l[i];
      // Processor write attempts during LOAD must be ignored.
      m_rw = 1'b1; m_addr = 6'h07; m_data = 16'hDEAD;
      @(negedge clock);
      tests++;
      if (cpu_run !== (i == 7) || load_ready !== (i != 7) || m_q !== '0) begin
        errors++;
        $display("FAIL load_step%0d: got run=%b ready=%b m_q=%h, want run=%b ready=%b m_q=0000",
                 i, cpu_run, load_ready, m_q, (i == 7), (i != 7));
      end
    end
    idle_inputs();
  endtask

  task automatic test_run_read();
    logic [AW-1:0] a [6] = '{6'h00, 6'h01, 6'h10, 6'h07, 6'h3F, 6'h20};
    logic [DW-1:0] e [6] = '{16'h1234, 16'hABCD, 16'h2222, 16'h0000, 16'h0000, 16'h5A5A};
    for (int i = 0; i < 6; i++) begin
      m_rw = 1'b0; m_addr = a[i];
      @(negedge clock);
      tests++;
      if (m_q !== e[i] || parity_err !== 1'b0) begin
        errors++;
        $display("FAIL run_read_%h: got m_q=%h perr=%b, want %h perr=0", a[i], m_q, parity_err, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Write 5 while the host tries to sneak a word into 6 (ignored in RUN).
    m_rw = 1'b1; m_addr = 6'h05; m_data = 16'hBEEF;
    load_valid = 1'b1; load_addr = 6'h06; load_data = 16'h6666; load_last = 1'b1;
    @(negedge clock);
    tests++;
    if (m_q !== 16'h0000) begin
      errors++;
      $display("FAIL write_readfirst: got m_q=%h, want 0000", m_q);
    end
    load_valid = 1'b0; load_last = 1'b0;
    m_rw = 1'b0; m_addr = 6'h05;
    @(negedge clock);
    tests++;
    if (m_q !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_after_write: got m_q=%h, want beef", m_q);
    end
    m_rw = 1'b1; m_addr = 6'h05; m_data = 16'h1357;
    @(negedge clock);
    tests++;
    if (m_q !== 16'hBEEF) begin
      errors++;
      $display("FAIL overwrite_readfirst: got m_q=%h, want beef", m_q);
    end
    m_rw = 1'b0; m_addr = 6'h06;
    @(negedge clock);
    tests++;
    if (m_q !== 16'h0000 || cpu_run !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL host_ignored_in_run: got m_q=%h run=%b ready=%b, want 0000 1 0",
               m_q, cpu_run, load_ready);
    end
    m_addr = 6'h05;
    @(negedge clock);
    tests++;
    if (m_q !== 16'h1357) begin
      errors++;
      $display("FAIL second_write: got m_q=%h, want 1357", m_q);
    end
  endtask

  task automatic test_parity();
`ifdef MEM_PARITY_EN
    dut.u_ram.mem[32][DW] = ~dut.u_ram.mem[32][DW];
    m_rw = 1'b0; m_addr = 6'h20;
    @(negedge clock);
    tests++;
    if (parity_err !== 1'b1 || m_q !== 16'h5A5A) begin
      errors++;
      $display("FAIL parity_detect: got perr=%b m_q=%h, want 1 5a5a", parity_err, m_q);
    end
    m_addr = 6'h00;
    repeat (3) @(negedge clock);
    tests++;
    if (parity_err !== 1'b1 || m_q !== 16'h1234) begin
      errors++;
      $display("FAIL parity_sticky: got perr=%b m_q=%h, want 1 1234", parity_err, m_q);
    end
`else
    m_rw = 1'b0; m_addr = 6'h20;
    @(negedge clock);
    tests++;
    if (parity_err !== 1'b0 || m_q !== 16'h5A5A) begin
      errors++;
      $display("FAIL parity_tied_low: got perr=%b m_q=%h, want 0 5a5a", parity_err, m_q);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    int n;
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cpu_run !== 1'b0 || m_q !== '0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_run: got run=%b m_q=%h perr=%b, want 0 0000 0", cpu_run, m_q, parity_err);
    end
    reset = 1'b0;
    count_clear(n);
    tests++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reclear_length: got %0d cycles, want %0d", n, DEPTH);
    end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_addr = AW'(6'h30 + i); load_data = DW'(16'hC000 + i); load_last = 1'b0;
      @(negedge clock);
    end
    // Fourth word presented together with reset: must not be written.
    load_valid = 1'b1; load_addr = 6'h33; load_data = 16'h9999; load_last = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cpu_run !== 1'b0 || load_ready !== 1'b0 || dut.u_ram.mem[51][DW-1:0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_load: got run=%b ready=%b mem33=%h, want 0 0 0000",
               cpu_run, load_ready, dut.u_ram.mem[51][DW-1:0]);
    end
    tests++;
    if (dut.u_ram.mem[50][DW-1:0] !== 16'hC002) begin
      errors++;
      $display("FAIL load_before_reset: got mem32=%h, want c002", dut.u_ram.mem[50][DW-1:0]);
    end
    idle_inputs();
    reset = 1'b0;
    count_clear(n);
    tests++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_after_abort: got %0d cycles, want %0d", n, DEPTH);
    end
    load_valid = 1'b1; load_addr = 6'h00; load_data = 16'h4242; load_last = 1'b1;
    @(negedge clock);
    idle_inputs();
    m_addr = 6'h32;
    @(negedge clock);
    tests++;
    if (cpu_run !== 1'b1 || m_q !== 16'h0000 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL run_after_reload: got run=%b m_q=%h perr=%b, want 1 0000 0", cpu_run, m_q, parity_err);
    end
    m_addr = 6'h00;
    @(negedge clock);
    tests++;
    if (m_q !== 16'h4242) begin
      errors++;
      $display("FAIL reload_word: got m_q=%h, want 4242", m_q);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_run_read();
    test_back_to_back();
    test_parity();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/simple_mem_responder.md
Name: simple_mem_responder

Overview:
- Memory-side responder for the processor's single memory port (m_addr/m_rw/m_data in, m_q out).
- Owns the 4096x16 unified instruction/data RAM and answers the processor's reads and writes with a fixed one-cycle read latency.
- Provides a host program-load port (valid/ready) and gates processor execution through `cpu_run`.
- Sequence after reset: optional clear, then program load, then processor run.

Parameters:
- `ADDR_W`, 12, address width; depth = 2**ADDR_W words.
- `DATA_W`, 16, word width.
- `CLEAR_ON_RESET`, 1, zero-fill the whole RAM after reset before accepting loads.

Ports:
- `clock`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `m_addr`  in  ADDR_W  processor word address.
- `m_rw`  in  1  processor write strobe: 1 = write, 0 = read.
- `m_data`  in  DATA_W  processor write data.
- `m_q`  out  DATA_W  registered read data to the processor.
- `load_valid`  in  1  host word valid.
- `load_ready`  out  1  responder accepts host word.
- `load_addr`  in  ADDR_W  host target address.
- `load_data`  in  DATA_W  host word.
- `load_last`  in  1  marks the final host word.
- `cpu_run`  out  1  processor may execute; drive the processor's exec from this.
- `parity_err`  out  1  sticky read parity error (see Optional Feature).

Behaviour:
- States: CLEAR, LOAD, RUN. Encoded as a 2-bit enum.
- Reset (synchronous):
  - State goes to CLEAR if `CLEAR_ON_RESET`=1, else LOAD.
  - Clear counter is set to 0.
  - `m_q`=0, `load_ready`=0, `cpu_run`=0, `parity_err`=0.
  - RAM contents are not reset; only CLEAR zeroes them.
  - Reset mid-load or mid-run aborts immediately; no partial write occurs in the reset cycle.
- CLEAR:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - When cnt = 2**ADDR_W-1 is written, go to LOAD. Total 2**ADDR_W cycles.
  - `load_ready`=0; processor inputs are ignored.
- LOAD:
  - `load_ready`=1.
  - Transfer occurs when `load_valid` & `load_ready` on a posedge; it writes mem[`load_addr`] <= `load_data`.
  - A transfer with `load_last`=1 moves to RUN next cycle. `load_ready` drops in that next cycle.
  - `load_valid`=0 holds the state indefinitely.
  - Duplicate addresses: the later word wins.
  - `m_q` is held at 0 and processor inputs are ignored.
- RUN:
  - `cpu_run`=1 and `load_ready`=0; host inputs are ignored.
  - Read (`m_rw`=0): `m_q` at the next posedge = mem[`m_addr`] as sampled at this posedge. Latency is exactly 1 cycle, every cycle, no stalls.
  - Write (`m_rw`=1): mem[`m_addr`] <= `m_data` at posedge. Read-first: `m_q` for that cycle returns the old contents.
  - A read of the address written in the previous cycle returns the new data.
  - RUN is left only by reset.
- Addresses: ADDR_W bits, no wrap logic needed; all values are valid.

Optional Feature:
- Macro: `MEM_PARITY_EN`.
- Defined:
  - RAM is DATA_W+1 bits wide and stores even parity (XOR of data) on every write: CLEAR, LOAD and RUN.
  - On each RUN read, the stored parity is checked. A mismatch sets `parity_err` at the same posedge `m_q` updates.
  - `parity_err` is sticky until reset. `m_q` still returns the stored data.
- Undefined: RAM is DATA_W wide and `parity_err` is tied to 0.

Decomposition:
- Shared package `simple_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - state enum type `mem_state_t` {CLEAR, LOAD, RUN}.
  - `m_rw` encoding constants (`MEM_READ`=0, `MEM_WRITE`=1).
- Sub-module `sp_ram`:
  - single-port synchronous RAM, one write port.
  - registered read-first output.
  - parameterised width/depth.
- `simple_mem_responder` holds the FSM, clear counter, write-port mux (clear / host / cpu), and parity logic.

Test Plan:
- Reset with `CLEAR_ON_RESET`=1 and `ADDR_W`=4:
  - `load_ready`=0 for exactly 16 cycles, then 1.
  - A subsequent RUN read of any address returns 0.
- Load 0x0000<-0x1234 and 0x0001<-0xABCD (last):
  - `cpu_run` rises the cycle after the last handshake.
  - RUN reads of addresses 0, 1 give `m_q`=0x1234, 0xABCD one cycle after each address.
- RUN write 0x005<-0xBEEF, then next-cycle read 0x005:
  - write-cycle `m_q` = old value.
  - read `m_q` = 0xBEEF.
- LOAD with `load_valid` gaps and duplicate address 0x010 (0x1111 then 0x2222):
  - no transfer without valid.
  - final contents 0x2222.
  - RUN inputs are ignored during LOAD.
- Assert reset mid-LOAD after 3 of 5 words:
  - state returns to CLEAR; `cpu_run`=0.
  - no write occurs on the reset edge.
- `MEM_PARITY_EN`: force-flip a stored parity bit at 0x020, then read it:
  - `parity_err` rises with `m_q`.
  - `parity_err` stays 1 until reset.
